// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// training from resolved control flow in Execute, mispredict flag and perf counters.
module branch_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  PCF,
  output logic             PredTakenF,
  output logic [XLEN-1:0]  PredPCNextF,
  input  logic             UpdateE,
  input  logic             IsJumpE,
  input  logic [XLEN-1:0]  PCE,
  input  logic             TakenE,
  input  logic [XLEN-1:0]  TargetE,
  input  logic             PredTakenE,
  input  logic [XLEN-1:0]  PredPCNextE,
  input  logic             FlushBTB,
  output logic             MispredictE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0]             jump_q, jump_d;
  logic [ENTRIES-1:0][1:0]        ctr_q, ctr_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][XLEN-1:0]   target_q, target_d;
  logic [CNT_W-1:0]               branch_count_q, branch_count_d;
  logic [CNT_W-1:0]               mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             unused_pc_lsbs;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[XLEN-1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  // Lookup reads only registered state, so a same-cycle update is not visible here.
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF  = hit_f && (jump_q[idx_f] || ctr_q[idx_f][1]);
    PredPCNextF = PredTakenF ? target_q[idx_f] : PCF + XLEN'(4);
  end

  always_comb begin
    MispredictE = UpdateE &&
                  ((PredTakenE != TakenE) || (TakenE && (PredPCNextE != TargetE)));
  end

  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  always_comb begin
    valid_d  = valid_q;
    jump_d   = jump_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (FlushBTB) begin
      valid_d = '0;
    end else if (UpdateE) begin
      if (hit_e) begin
        if (TakenE) begin
          if (ctr_q[idx_e] != 2'b11) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
          target_d[idx_e] = TargetE;
        end else begin
          if (ctr_q[idx_e] != 2'b00) ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
        end
        jump_d[idx_e] = IsJumpE;
      end else if (TakenE) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = TargetE;
        jump_d[idx_e]   = IsJumpE;
        ctr_d[idx_e]    = IsJumpE ? 2'b11 : 2'b10;
      end
    end
  end

  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (UpdateE && (branch_count_q != '1))
      branch_count_d = branch_count_q + CNT_W'(1);
    if (MispredictE && (mispred_count_q != '1))
      mispred_count_d = mispred_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q         <= '0;
      jump_q          <= '0;
      ctr_q           <= '0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      valid_q         <= valid_d;
      jump_q          <= jump_d;
      ctr_q           <= ctr_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Tag/target are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign BranchCount  = branch_count_q;
  assign MispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against an array-based behavioural model.
module tb_branch_predictor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMAX  = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      PCF, PCE, TargetE, PredPCNextE, PredPCNextF;
  logic             PredTakenF, UpdateE, IsJumpE, TakenE, PredTakenE, FlushBTB, MispredictE;
  logic [CNT_W-1:0] BranchCount, MispredCount;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCNextF(PredPCNextF),
    .UpdateE(UpdateE), .IsJumpE(IsJumpE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredPCNextE(PredPCNextE), .FlushBTB(FlushBTB),
    .MispredictE(MispredictE), .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one record per BTB slot, plain integers throughout.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  bit          m_jump  [16];
  int          m_ctr   [16];
  int unsigned m_bc, m_mc;

  bit          obs_pt, obs_mis;
  logic [31:0] obs_pcn;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_jump[i] = 0; m_ctr[i] = 0;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic void predict(input int unsigned pc, output bit t, output int unsigned nxt);
    int unsigned i = (pc / 4) % 16;
    t   = m_valid[i] && (m_tag[i] == pc / 64) && (m_jump[i] || m_ctr[i] >= 2);
    nxt = t ? m_tgt[i] : pc + 4;
  endfunction

  task automatic step(input int unsigned pcf, input bit upd, input bit jmp,
                      input int unsigned pce, input bit te, input int unsigned tgt,
                      input bit pte, input int unsigned ppe, input bit flush);
    bit          et, emis;
    int unsigned enx, i, tg;
    @(negedge clk);
    PCF = pcf; UpdateE = upd; IsJumpE = jmp; PCE = pce; TakenE = te; TargetE = tgt;
    PredTakenE = pte; PredPCNextE = ppe; FlushBTB = flush;
    #1;
    predict(pcf, et, enx);
    emis = upd && ((pte != te) || (te && ppe != tgt));
    obs_pt = PredTakenF; obs_pcn = PredPCNextF; obs_mis = MispredictE;
    check("pred_taken", {31'd0, PredTakenF}, {31'd0, et});
    check("pred_pc", PredPCNextF, enx);
    check("mispredict", {31'd0, MispredictE}, {31'd0, emis});
    check("branch_count", {24'd0, BranchCount}, m_bc);
    check("mispred_count", {24'd0, MispredCount}, m_mc);
    @(posedge clk);
    if (upd && m_bc < CMAX) m_bc++;
    if (emis && m_mc < CMAX) m_mc++;
    i = (pce / 4) % 16; tg = pce / 64;
    if (flush) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (upd) begin
      if (m_valid[i] && m_tag[i] == tg) begin
        if (te) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
        m_jump[i] = jmp;
      end else if (te) begin
        m_valid[i] = 1; m_tag[i] = tg; m_tgt[i] = tgt; m_jump[i] = jmp;
        m_ctr[i] = jmp ? 3 : 2;
      end
    end
  endtask

  task automatic lookup(input int unsigned pcf);
    step(pcf, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_inputs();
    UpdateE = 0; FlushBTB = 0; IsJumpE = 0; TakenE = 0; PredTakenE = 0;
    PCE = '0; TargetE = '0; PredPCNextE = '0;
  endtask

  initial begin
    bit          pt;
    int unsigned pn, pce, tgt;
    reset = 0; PCF = 32'h40; idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_branch_count", {24'd0, BranchCount}, 0);
    check("rst_pred_taken", {31'd0, PredTakenF}, 0);
    @(negedge clk);
    reset = 1;

    // 1. cold lookup
    lookup(32'h40);
    check("cold_taken", {31'd0, obs_pt}, 0);
    check("cold_pc", obs_pcn, 32'h44);

    // 2. first taken branch allocates
    step(32'h40, 1, 0, 32'h40, 1, 32'h10, 0, 32'h44, 0);
    check("alloc_mispredict", {31'd0, obs_mis}, 1);
    lookup(32'h40);
    check("alloc_taken", {31'd0, obs_pt}, 1);
    check("alloc_pc", obs_pcn, 32'h10);

    // 3. not-taken training saturates at 00
    step(32'h40, 1, 0, 32'h40, 0, 32'h10, 1, 32'h10, 0);
    check("nt1_pre_taken", {31'd0, obs_pt}, 1);
    step(32'h40, 1, 0, 32'h40, 0, 32'h10, 0, 32'h44, 0);
    check("nt2_taken", {31'd0, obs_pt}, 0);
    step(32'h40, 1, 0, 32'h40, 0, 32'h10, 0, 32'h44, 0);
    lookup(32'h40);
    check("nt_sat_taken", {31'd0, obs_pt}, 0);

    // 4. alias at the same index with a different tag
    step(32'h440, 1, 0, 32'h440, 1, 32'h300, 0, 32'h444, 0);
    lookup(32'h40);
    check("alias_old_pc", obs_pcn, 32'h44);
    lookup(32'h440);
    check("alias_new_taken", {31'd0, obs_pt}, 1);
    check("alias_new_pc", obs_pcn, 32'h300);

    // 5. jump entry stays taken despite not-taken training, then flush beats update
    step(32'h80, 1, 1, 32'h80, 1, 32'h200, 0, 32'h84, 0);
    step(32'h80, 1, 1, 32'h80, 0, 32'h200, 1, 32'h200, 0);
    step(32'h80, 1, 1, 32'h80, 0, 32'h200, 1, 32'h200, 0);
    lookup(32'h80);
    check("jump_taken", {31'd0, obs_pt}, 1);
    check("jump_pc", obs_pcn, 32'h200);
    step(32'h80, 1, 0, 32'h100, 1, 32'h500, 0, 32'h104, 1);
    lookup(32'h80);
    check("flush_miss_80", {31'd0, obs_pt}, 0);
    lookup(32'h100);
    check("flush_no_alloc", obs_pcn, 32'h104);

    // randomized traffic over a small pool of aliasing PCs
    for (int n = 0; n < 500; n++) begin
      pce = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt = pce + 32'h20;
      predict(pce, pt, pn);
      if ($urandom_range(0, 1) == 0) begin
        pt = $urandom_range(0, 1);
        pn = ($urandom_range(0, 1) == 0) ? tgt : $urandom;
      end
      step(($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0), pce,
           ($urandom_range(0, 9) < 6), tgt, pt, pn, ($urandom_range(0, 32) == 0));
    end

    // 6. counter saturation, then asynchronous reset mid-run
    for (int n = 0; n < 260; n++) step(32'h40, 1, 0, $urandom, 0, 0, 0, 0, 0);
    lookup(32'h40);
    check("bcount_sat", {24'd0, BranchCount}, 32'hFF);
    @(negedge clk);
    PCF = 32'h440; UpdateE = 1; PredTakenE = 1; TakenE = 0; FlushBTB = 0;
    #2 reset = 0;
    #1;
    check("async_bcount", {24'd0, BranchCount}, 0);
    check("async_mcount", {24'd0, MispredCount}, 0);
    check("async_taken", {31'd0, PredTakenF}, 0);
    check("async_pc", PredPCNextF, 32'h444);
    check("async_mispredict", {31'd0, MispredictE}, 1);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1;
    for (int n = 0; n < 40; n++) begin
      pce = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 7) << 2);
      predict(pce, pt, pn);
      step(pce, 1, 0, pce, $urandom_range(0, 1), pce + 32'h40, pt, pn, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
